wb_stage: RTL and testbench

Writeback stage of the five-stage RV32I pipeline, directly downstream of the MEM stage. It owns the MEM/WB pipeline register and sequences the data-memory handshake: it stalls the pipeline until a load or store completes, and holds the returned data if another stall source freezes the pipe. It extracts and extends load data, selects the register-file write value, drives the WB forwarding path, and emits the RVFI commit record.

---
 rtl/rv32i_types.sv | 67 ++++++
 rtl/load_extend.sv | 43 ++++
 rtl/wb_stage.sv | 180 ++++++++++++++++++
 tb/tb_wb_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the RV32I pipeline slice around the
// writeback stage.
//   wb_state_t          - writeback memory-handshake state (IDLE/WAIT/HOLD)
//   regfilemux_sel_t    - register-file write value select
//   access_length_t     - load/store access width
//   rv32i_ctrl_word     - per-instruction control word travelling down the pipe
//   rv32i_monitor_word  - RVFI commit record
//   mem_wb_reg_t        - contents of the MEM/WB pipeline register
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } wb_state_t;

    typedef enum logic [2:0] {
        RF_ALU_OUT   = 3'd0,
        RF_BR_EN     = 3'd1,
        RF_U_IMM     = 3'd2,
        RF_PC_PLUS4  = 3'd3,
        RF_MEM_RDATA = 3'd4
    } regfilemux_sel_t;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd2
    } access_length_t;

    typedef struct packed {
        logic            mem_read;
        logic            mem_write;
        logic            regfile_write;
        regfilemux_sel_t regfilemux_sel;
        access_length_t  access_length;
        logic            access_sign;     // 1 = sign-extend loads
    } rv32i_ctrl_word;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rv32i_monitor_word;

    typedef struct packed {
        logic              valid;
        rv32i_ctrl_word    ctrl;
        logic [31:0]       alu_out;
        logic [31:0]       u_imm;
        logic [31:0]       pc;
        logic              br_en;
        logic [4:0]        rd_addr;
        logic [31:0]       rdata;
        rv32i_monitor_word monitor;
    } mem_wb_reg_t;

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load-data lane extraction and extension.
//   rdata         in  32  raw word returned by data memory
//   offset        in  2   byte offset within the word (alu_out[1:0])
//   access_length in      byte / half / word
//   access_sign   in  1   1 = sign-extend, 0 = zero-extend
//   ext_data      out 32  extracted, extended value (0 when misaligned)
module load_extend
    import rv32i_types::*;
(
    input  logic [31:0]    rdata,
    input  logic [1:0]     offset,
    input  access_length_t access_length,
    input  logic           access_sign,
    output logic [31:0]    ext_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext_data = '0;
        case (access_length)
            LEN_BYTE: ext_data = {{24{access_sign & byte_lane[7]}}, byte_lane};
            // Misaligned halves and words return 0 rather than a rotated word.
            LEN_HALF: if (!offset[0]) ext_data = {{16{access_sign & half_lane[15]}}, half_lane};
            LEN_WORD: if (offset == 2'd0) ext_data = rdata;
            default:  ext_data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the five-stage RV32I pipeline. Owns the
// MEM/WB register, sequences the data-memory handshake, extends load data,
// drives the register-file write port, the WB forwarding path and the RVFI
// commit record.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mem_*                instruction and datapath values leaving MEM
//   data_mem_rdata/resp  memory read data and one-cycle response pulse
//   ext_stall            freeze request from other pipeline sources
//   data_mem_req_en      qualifier ANDed onto MEM's read/write strobes
//   pipe_stall           global pipeline freeze
//   regfile_*            register-file write port
//   wb_fwd_rs_*          forwarding source (zeroed when nothing is written)
//   wb_commit            instruction retires this cycle
//   wb_monitor_word      RVFI record (all zero unless RVFI_MONITOR_EN)
//   dbg_state            current handshake state, for observation only
//
// Build option: define RVFI_MONITOR_EN to build the RVFI record and its
// 64-bit commit order counter.
//
// Handshake: a memory op sits in MEM (mem_op) until data_mem_resp pulses; the
// request strobe stays qualified (req_en) until then. If ext_stall freezes the
// pipe in the response cycle, the data is captured into held_rdata and req_en
// drops so the access is not re-issued while MEM still presents it. The MEM/WB
// register loads only when pipe_stall is low; otherwise it loads a bubble.
module wb_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  rv32i_ctrl_word    mem_ctrlword,
    input  logic [31:0]       mem_alu_out,
    input  logic [31:0]       mem_u_imm,
    input  logic [31:0]       mem_pc,
    input  logic              mem_br_en,
    input  logic [4:0]        mem_rd_addr,
    input  rv32i_monitor_word mem_monitor_word,
    input  logic [31:0]       data_mem_rdata,
    input  logic              data_mem_resp,
    input  logic              ext_stall,
    output logic              data_mem_req_en,
    output logic              pipe_stall,
    output logic              regfile_we,
    output logic [4:0]        regfile_rd_addr,
    output logic [31:0]       regfile_wdata,
    output logic [4:0]        wb_fwd_rs_addr,
    output logic [31:0]       wb_fwd_rs_data,
    output logic              wb_commit,
    output rv32i_monitor_word wb_monitor_word,
    output wb_state_t         dbg_state
);

    wb_state_t   state, state_next;
    logic        mem_op;
    logic        resp_hit;
    logic        capture;
    logic        advance;
    logic [31:0] held_rdata;
    logic [31:0] load_data;
    mem_wb_reg_t wb, wb_next;

    assign mem_op   = mem_valid & (mem_ctrlword.mem_read | mem_ctrlword.mem_write);
    // A response outside a memory op is stray and must not move the FSM.
    assign resp_hit = mem_op & data_mem_resp;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next      = state;
        data_mem_req_en = 1'b1;
        capture         = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !data_mem_resp) begin
                    state_next = WAIT;
                end else if (resp_hit && ext_stall) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            WAIT: begin
                if (resp_hit) begin
                    if (ext_stall) begin
                        state_next = HOLD;
                        capture    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HOLD: begin
                data_mem_req_en = 1'b0;
                if (!ext_stall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state  = state;
    assign pipe_stall = ext_stall | (mem_op & (state != HOLD) & !data_mem_resp);
    assign advance    = !pipe_stall;

    always_ff @(posedge clk) begin
        if (rst)          held_rdata <= '0;
        else if (capture) held_rdata <= data_mem_rdata;
    end

    always_comb begin
        wb_next         = '0;
        wb_next.valid   = mem_valid;
        wb_next.ctrl    = mem_ctrlword;
        wb_next.alu_out = mem_alu_out;
        wb_next.u_imm   = mem_u_imm;
        wb_next.pc      = mem_pc;
        wb_next.br_en   = mem_br_en;
        wb_next.rd_addr = mem_rd_addr;
        // Leaving HOLD, the live bus may already carry unrelated data.
        wb_next.rdata   = (state == HOLD) ? held_rdata : data_mem_rdata;
        wb_next.monitor = mem_monitor_word;
    end

    // A stalled cycle loads a bubble so the instruction commits only once.
    always_ff @(posedge clk) begin
        if (rst)          wb <= '0;
        else if (advance) wb <= wb_next;
        else              wb <= '0;
    end

    load_extend u_load_extend (
        .rdata         (wb.rdata),
        .offset        (wb.alu_out[1:0]),
        .access_length (wb.ctrl.access_length),
        .access_sign   (wb.ctrl.access_sign),
        .ext_data      (load_data)
    );

    always_comb begin
        regfile_wdata = '0;
        case (wb.ctrl.regfilemux_sel)
            RF_ALU_OUT:   regfile_wdata = wb.alu_out;
            RF_BR_EN:     regfile_wdata = {31'b0, wb.br_en};
            RF_U_IMM:     regfile_wdata = wb.u_imm;
            RF_PC_PLUS4:  regfile_wdata = wb.pc + 32'd4;
            RF_MEM_RDATA: regfile_wdata = load_data;
            default:      regfile_wdata = '0;
        endcase
    end

    assign regfile_we      = wb.valid & wb.ctrl.regfile_write & (wb.rd_addr != 5'd0);
    assign regfile_rd_addr = wb.rd_addr;
    assign wb_fwd_rs_addr  = regfile_we ? wb.rd_addr : 5'd0;
    assign wb_fwd_rs_data  = regfile_we ? regfile_wdata : 32'd0;
    assign wb_commit       = wb.valid;

`ifdef RVFI_MONITOR_EN
    logic [63:0] order_cnt;

    always_ff @(posedge clk) begin
        if (rst)            order_cnt <= '0;
        else if (wb_commit) order_cnt <= order_cnt + 64'd1;
    end

    always_comb begin
        wb_monitor_word           = wb.monitor;
        wb_monitor_word.valid     = wb_commit;
        wb_monitor_word.order     = order_cnt;
        wb_monitor_word.rd_addr   = regfile_we ? wb.rd_addr : 5'd0;
        wb_monitor_word.rd_wdata  = regfile_we ? regfile_wdata : 32'd0;
        wb_monitor_word.mem_rdata = wb.rdata;
    end
`else
    assign wb_monitor_word = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
module tb_wb_stage;
    import rv32i_types::*;

    logic              clk;
    logic              rst;
    logic              mem_valid;
    rv32i_ctrl_word    mem_ctrlword;
    logic [31:0]       mem_alu_out;
    logic [31:0]       mem_u_imm;
    logic [31:0]       mem_pc;
    logic              mem_br_en;
    logic [4:0]        mem_rd_addr;
    rv32i_monitor_word mem_monitor_word;
    logic [31:0]       data_mem_rdata;
    logic              data_mem_resp;
    logic              ext_stall;
    logic              data_mem_req_en;
    logic              pipe_stall;
    logic              regfile_we;
    logic [4:0]        regfile_rd_addr;
    logic [31:0]       regfile_wdata;
    logic [4:0]        wb_fwd_rs_addr;
    logic [31:0]       wb_fwd_rs_data;
    logic              wb_commit;
    rv32i_monitor_word wb_monitor_word;
    wb_state_t         dbg_state;

    int checks   = 0;
    int failures = 0;
    int commits  = 0;

    wb_stage dut (
        .clk              (clk),
        .rst              (rst),
        .mem_valid        (mem_valid),
        .mem_ctrlword     (mem_ctrlword),
        .mem_alu_out      (mem_alu_out),
        .mem_u_imm        (mem_u_imm),
        .mem_pc           (mem_pc),
        .mem_br_en        (mem_br_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_monitor_word (mem_monitor_word),
        .data_mem_rdata   (data_mem_rdata),
        .data_mem_resp    (data_mem_resp),
        .ext_stall        (ext_stall),
        .data_mem_req_en  (data_mem_req_en),
        .pipe_stall       (pipe_stall),
        .regfile_we       (regfile_we),
        .regfile_rd_addr  (regfile_rd_addr),
        .regfile_wdata    (regfile_wdata),
        .wb_fwd_rs_addr   (wb_fwd_rs_addr),
        .wb_fwd_rs_data   (wb_fwd_rs_data),
        .wb_commit        (wb_commit),
        .wb_monitor_word  (wb_monitor_word),
        .dbg_state        (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver helpers
    function automatic rv32i_ctrl_word mk_ctrl(input logic rd, input logic rfw,
                                               input logic [2:0] sel,
                                               input access_length_t len,
                                               input logic sgn);
        rv32i_ctrl_word c;
        c = '0;
        c.mem_read       = rd;
        c.regfile_write  = rfw;
        c.regfilemux_sel = regfilemux_sel_t'(sel);
        c.access_length  = len;
        c.access_sign    = sgn;
        return c;
    endfunction

    task automatic drive_idle();
        @(negedge clk);
        mem_valid        = 1'b0;
        mem_ctrlword     = '0;
        mem_alu_out      = '0;
        mem_u_imm        = '0;
        mem_pc           = '0;
        mem_br_en        = 1'b0;
        mem_rd_addr      = '0;
        mem_monitor_word = '0;
        data_mem_rdata   = '0;
        data_mem_resp    = 1'b0;
        ext_stall        = 1'b0;
    endtask

    // Present one instruction in MEM at the next falling edge.
    task automatic drive_instr(input rv32i_ctrl_word c, input logic [31:0] alu,
                               input logic [31:0] uimm, input logic [31:0] pc,
                               input logic br, input logic [4:0] rd,
                               input logic [31:0] rdata, input logic resp,
                               input logic stall);
        @(negedge clk);
        mem_valid      = 1'b1;
        mem_ctrlword   = c;
        mem_alu_out    = alu;
        mem_u_imm      = uimm;
        mem_pc         = pc;
        mem_br_en      = br;
        mem_rd_addr    = rd;
        data_mem_rdata = rdata;
        data_mem_resp  = resp;
        ext_stall      = stall;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wb_commit) commits++;
    endtask

    // Scoreboard check
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle load with immediate response; returns after WB shows it.
    task automatic load_now(input string tag, input access_length_t len, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] exp);
        drive_instr(mk_ctrl(1'b1, 1'b1, RF_MEM_RDATA, len, sgn), addr, 32'h0, 32'h0,
                    1'b0, 5'd4, rdata, 1'b1, 1'b0);
        #1 check({tag, "_stall"}, 64'(pipe_stall), 64'd0);
        tick();
        check(tag, 64'(regfile_wdata), 64'(exp));
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_we",     64'(regfile_we),      64'd0);
        check("rst_wdata",  64'(regfile_wdata),   64'd0);
        check("rst_commit", 64'(wb_commit),       64'd0);
        check("rst_req_en", 64'(data_mem_req_en), 64'd1);
        check("rst_stall",  64'(pipe_stall),      64'd0);
        check("rst_state",  64'(dbg_state),       64'(IDLE));
        check("rst_fwd",    64'({wb_fwd_rs_addr, wb_fwd_rs_data}), 64'd0);
        checks++;
        assert (wb_monitor_word === '0) else begin
            failures++;
            $error("FAIL rst_monitor observed=0x%0h expected=0x0", wb_monitor_word);
        end

        // LW with same-cycle response
        drive_instr(mk_ctrl(1'b1, 1'b1, RF_MEM_RDATA, LEN_WORD, 1'b0), 32'h100, 32'h0,
                    32'h0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
        #1 check("lw_stall", 64'(pipe_stall), 64'd0);
        tick();
        check("lw_we",     64'(regfile_we),      64'd1);
        check("lw_rd",     64'(regfile_rd_addr), 64'd5);
        check("lw_wdata",  64'(regfile_wdata),   64'hDEADBEEF);
        check("lw_commit", 64'(wb_commit),       64'd1);
        check("lw_fwd",    64'({wb_fwd_rs_addr, wb_fwd_rs_data}), {27'd0, 5'd5, 32'hDEADBEEF});

        // Load extraction
        load_now("lb_off3",  LEN_BYTE, 1'b1, 32'h203, 32'h80FF1234, 32'hFFFFFF80);
        load_now("lbu_off1", LEN_BYTE, 1'b0, 32'h201, 32'h80FF1234, 32'h00000012);
        load_now("lhu_off2", LEN_HALF, 1'b0, 32'h202, 32'h80FF1234, 32'h000080FF);
        load_now("lh_off0",  LEN_HALF, 1'b1, 32'h200, 32'h80FF1234, 32'h00001234);
        load_now("lh_off2",  LEN_HALF, 1'b1, 32'h202, 32'h80FF1234, 32'hFFFF80FF);
        load_now("lh_mis1",  LEN_HALF, 1'b1, 32'h201, 32'h80FF1234, 32'h00000000);
        load_now("lw_mis2",  LEN_WORD, 1'b0, 32'h202, 32'h80FF1234, 32'h00000000);

        // Load with response after three stalled cycles
        drive_idle();
        tick();
        commits = 0;
        for (int i = 0; i < 3; i++) begin
            drive_instr(mk_ctrl(1'b1, 1'b1, RF_MEM_RDATA, LEN_WORD, 1'b0), 32'h300, 32'h0,
                        32'h0, 1'b0, 5'd7, 32'h11112222, 1'b0, 1'b0);
            #1 check($sformatf("wait_stall%0d", i), 64'(pipe_stall), 64'd1);
            tick();
            check($sformatf("wait_we%0d", i),    64'(regfile_we), 64'd0);
            check($sformatf("wait_state%0d", i), 64'(dbg_state),  64'(WAIT));
        end
        drive_instr(mk_ctrl(1'b1, 1'b1, RF_MEM_RDATA, LEN_WORD, 1'b0), 32'h300, 32'h0,
                    32'h0, 1'b0, 5'd7, 32'h11112222, 1'b1, 1'b0);
        #1 check("wait_resp_stall", 64'(pipe_stall), 64'd0);
        tick();
        check("wait_wdata", 64'(regfile_wdata), 64'h11112222);
        check("wait_state_idle", 64'(dbg_state), 64'(IDLE));
        drive_idle();
        tick();
        check("wait_one_commit", 64'(commits), 64'd1);

        // Response under ext_stall -> HOLD, data bus then forced to 0
        drive_instr(mk_ctrl(1'b1, 1'b1, RF_MEM_RDATA, LEN_WORD, 1'b0), 32'h400, 32'h0,
                    32'h0, 1'b0, 5'd9, 32'hCAFEF00D, 1'b1, 1'b1);
        #1 check("hold_stall0", 64'(pipe_stall), 64'd1);
        tick();
        check("hold_state",  64'(dbg_state),       64'(HOLD));
        check("hold_req_en", 64'(data_mem_req_en), 64'd0);
        check("hold_commit", 64'(wb_commit),       64'd0);
        for (int i = 0; i < 2; i++) begin
            drive_instr(mk_ctrl(1'b1, 1'b1, RF_MEM_RDATA, LEN_WORD, 1'b0), 32'h400, 32'h0,
                        32'h0, 1'b0, 5'd9, 32'h0, 1'b0, 1'b1);
            #1 check($sformatf("hold_stall%0d", i + 1), 64'(pipe_stall), 64'd1);
            tick();
            check($sformatf("hold_req_en%0d", i + 1), 64'(data_mem_req_en), 64'd0);
        end
        drive_instr(mk_ctrl(1'b1, 1'b1, RF_MEM_RDATA, LEN_WORD, 1'b0), 32'h400, 32'h0,
                    32'h0, 1'b0, 5'd9, 32'h0, 1'b0, 1'b0);
        #1 check("hold_release_stall", 64'(pipe_stall), 64'd0);
        tick();
        check("hold_wdata",  64'(regfile_wdata), 64'hCAFEF00D);
        check("hold_we",     64'(regfile_we),    64'd1);
        check("hold_idle",   64'(dbg_state),     64'(IDLE));
        check("hold_req_on", 64'(data_mem_req_en), 64'd1);

        // ALU, rd = 0
        drive_instr(mk_ctrl(1'b0, 1'b1, RF_ALU_OUT, LEN_WORD, 1'b0), 32'h55, 32'h0,
                    32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
        check("x0_we",     64'(regfile_we),     64'd0);
        check("x0_fwd",    64'({wb_fwd_rs_addr, wb_fwd_rs_data}), 64'd0);
        check("x0_commit", 64'(wb_commit),      64'd1);

        // ALU, rd = 3, plus stray response ignored
        drive_instr(mk_ctrl(1'b0, 1'b1, RF_ALU_OUT, LEN_WORD, 1'b0), 32'h12345678, 32'h0,
                    32'h0, 1'b0, 5'd3, 32'hFFFFFFFF, 1'b1, 1'b0);
        #1 check("alu_stall", 64'(pipe_stall), 64'd0);
        tick();
        check("alu_fwd",   64'({wb_fwd_rs_addr, wb_fwd_rs_data}), {27'd0, 5'd3, 32'h12345678});
        check("alu_state", 64'(dbg_state), 64'(IDLE));

        // JAL / pc + 4, including wrap
        drive_instr(mk_ctrl(1'b0, 1'b1, RF_PC_PLUS4, LEN_WORD, 1'b0), 32'h0, 32'h0,
                    32'h60, 1'b0, 5'd1, 32'h0, 1'b0, 1'b0);
        tick();
        check("jal_wdata", 64'(regfile_wdata), 64'h64);
        drive_instr(mk_ctrl(1'b0, 1'b1, RF_PC_PLUS4, LEN_WORD, 1'b0), 32'h0, 32'h0,
                    32'hFFFFFFFC, 1'b0, 5'd1, 32'h0, 1'b0, 1'b0);
        tick();
        check("jal_wrap", 64'(regfile_wdata), 64'h0);

        // br_en, u_imm, invalid select
        drive_instr(mk_ctrl(1'b0, 1'b1, RF_BR_EN, LEN_WORD, 1'b0), 32'hAAAA, 32'h0,
                    32'h0, 1'b1, 5'd2, 32'h0, 1'b0, 1'b0);
        tick();
        check("br_en", 64'(regfile_wdata), 64'h1);
        drive_instr(mk_ctrl(1'b0, 1'b1, RF_U_IMM, LEN_WORD, 1'b0), 32'hAAAA, 32'hABCDE000,
                    32'h0, 1'b0, 5'd2, 32'h0, 1'b0, 1'b0);
        tick();
        check("u_imm", 64'(regfile_wdata), 64'hABCDE000);
        drive_instr(mk_ctrl(1'b0, 1'b1, 3'd7, LEN_WORD, 1'b0), 32'hAAAA, 32'h1,
                    32'h0, 1'b0, 5'd2, 32'h0, 1'b0, 1'b0);
        tick();
        check("bad_sel", 64'(regfile_wdata), 64'h0);

        // Bubble from MEM
        drive_idle();
        tick();
        check("bubble_commit", 64'(wb_commit), 64'd0);

        // Reset while in WAIT
        drive_instr(mk_ctrl(1'b1, 1'b1, RF_MEM_RDATA, LEN_WORD, 1'b0), 32'h500, 32'h0,
                    32'h0, 1'b0, 5'd8, 32'h0, 1'b0, 1'b0);
        tick();
        check("pre_rst_state", 64'(dbg_state), 64'(WAIT));
        drive_idle();
        rst = 1'b1;
        tick();
        check("rst_wait_state",  64'(dbg_state),       64'(IDLE));
        check("rst_wait_req_en", 64'(data_mem_req_en), 64'd1);
        check("rst_wait_stall",  64'(pipe_stall),      64'd0);
        check("rst_wait_commit", 64'(wb_commit),       64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Three commits after reset
        for (int i = 0; i < 3; i++) begin
            drive_instr(mk_ctrl(1'b0, 1'b1, RF_ALU_OUT, LEN_WORD, 1'b0), 32'h10 + 32'(i),
                        32'h0, 32'h80, 1'b0, 5'd6, 32'h0, 1'b0, 1'b0);
            mem_monitor_word.inst = 32'h00000013;
            tick();
            check($sformatf("post_rst_commit%0d", i), 64'(wb_commit), 64'd1);
`ifdef RVFI_MONITOR_EN
            check($sformatf("mon_order%0d", i), wb_monitor_word.order,          64'(i));
            check($sformatf("mon_valid%0d", i), 64'(wb_monitor_word.valid),     64'd1);
            check($sformatf("mon_inst%0d", i),  64'(wb_monitor_word.inst),      64'h13);
            check($sformatf("mon_rd%0d", i),    64'(wb_monitor_word.rd_addr),   64'd6);
            check($sformatf("mon_wd%0d", i),    64'(wb_monitor_word.rd_wdata),  64'(32'h10 + 32'(i)));
`else
            checks++;
            assert (wb_monitor_word === '0) else begin
                failures++;
                $error("FAIL mon_tied%0d observed=0x%0h expected=0x0", i, wb_monitor_word);
            end
`endif
        end
        drive_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
